tmds_lane_serializer: RTL and testbench
=======================================

Name: tmds_lane_serializer

Overview:
- Parametrised successor to the fixed 4-lane, SDR/DDR TMDS output stage that feeds the fake-differential video pins.
- Takes C_lanes parallel C_bits-wide encoded words and serialises each lane LSB-first.
- Runs entirely in the shift clock domain: an internal phase counter owns word timing, and a holding register decouples the word producer from the load instant.
- Adds per-lane polarity inversion, underrun detection with last-word repeat, and a load strobe for upstream alignment.

Parameters:
- C_lanes, 4, number of serial lanes (clock lane counts as one).
- C_bits, 10, word width per lane; must be even when C_ddr=1.
- C_ddr, 1, 0: one bit per lane per clock; 1: two bits per lane per clock.
- C_invert, 0, C_lanes-bit mask; bit i=1 inverts every output bit of lane i.

Ports:
- clk_shift  in  1  shift clock (pixel clock × C_bits, or × C_bits/2 when DDR).
- reset  in  1  synchronous, active-high.
- in_word  in  C_lanes*C_bits  lane i in bits [i*C_bits +: C_bits].
- in_valid  in  1  one-cycle strobe; captures in_word into the holding register.
- load_strobe  out  1  high in the cycle the shift register reloads.
- out_d  out  2*C_lanes  lane i on [2i+1:2i]; bit 2i is sent first.
- underrun  out  1  sticky; set when a load finds no fresh word.
- underrun_cnt  out  8  saturating count of underrun loads.

Behaviour:
- Per-word cycle count N = C_bits (SDR) or C_bits/2 (DDR).
- Phase counter p runs 0..N-1 and wraps to 0.
- load_strobe = (p == N-1). It is decoded from registered p, so it has no input path.
- In-cycle-of-load: the shift register takes the holding register value, or in_word directly if in_valid is high in that same cycle (bypass). The new word is visible from the next cycle, p=0.
- Shifting, SDR: each cycle lane shift register shifts right 1. out_d[2i] = out_d[2i+1] = sr_i[0] ^ C_invert[i].
- Shifting, DDR: each cycle shifts right 2. out_d[2i] = sr_i[0] ^ inv, out_d[2i+1] = sr_i[1] ^ inv.
- Outputs are taken straight from registered state. Latency: a word loaded at cycle L shows its first bit(s) in cycle L+1; all bits are done by cycle L+N.
- Fresh flag: set by in_valid, cleared at each load.
  - Load with the flag clear and in_valid low: repeat the holding word, set underrun, increment underrun_cnt (saturates at 255).
  - in_valid during a load counts as fresh; no underrun.
- Multiple in_valid between loads: last one wins; no error.
- Reset (any cycle, including mid-word):
  - p=0, shift registers=0, holding=0, fresh flag=0, underrun=0, underrun_cnt=0.
  - out_d[2i+1:2i] = {2{C_invert[i]}}; load_strobe=0 until p reaches N-1 (first load N-1 cycles after reset deasserts).
  - underrun and underrun_cnt clear only on reset.
- Lane independence: all lanes share p and the load; no cross-lane data mixing.
- Zero RTL-visible state outside the shift, holding, counter and flag registers.
- Serialiser SDR/DDR primitives are downstream, not in this block.

Test Plan:
- SDR, C_lanes=1, in_word=10'h2AB pulsed before the first load → out_d[0] for cycles L+1..L+10 = 1,1,0,1,0,1,0,1,0,1; load_strobe period 10.
- DDR, C_lanes=4, every lane 10'h2AB → each lane pair over 5 cycles = 2'b11,10,10,10,10; load_strobe period 5; all lanes identical.
- Underrun: load word 10'h155, then no in_valid for 3 loads → 10'h155 repeated 3×; underrun=1; underrun_cnt=3. Force 300 underruns → count holds 255.
- Bypass: in_valid with 10'h3FF coincident with load_strobe, holding=10'h000 → the next word is 3FF and underrun is unchanged.
- C_invert=4'b1000, DDR, all lanes 10'h000 → lane 3 pair 2'b11 every cycle, lanes 0–2 2'b00; reset output lane 3 = 2'b11.
- Reset asserted at p=3 mid-word → next cycle all state zero, out_d = inverted mask; first load_strobe N-1 cycles after reset release; counter and flag cleared.

Source files
------------

// File: rtl/tmds_lane_serializer.sv
// Multi-lane TMDS word serialiser, LSB-first, SDR or DDR per lane.
// Word timing comes from an internal phase counter; a holding register buffers the producer.
module tmds_lane_serializer #(
   parameter int                 C_lanes  = 4,
   parameter int                 C_bits   = 10,
   parameter int                 C_ddr    = 1,
   parameter logic [C_lanes-1:0] C_invert = '0
) (
   input  logic                      clk_shift,
   input  logic                      reset,
   input  logic [C_lanes*C_bits-1:0] in_word,
   input  logic                      in_valid,
   output logic                      load_strobe,
   output logic [2*C_lanes-1:0]      out_d,
   output logic                      underrun,
   output logic [7:0]                underrun_cnt
);

   localparam int N    = (C_ddr != 0) ? C_bits / 2 : C_bits;
   localparam int PW   = (N > 1) ? $clog2(N) : 1;
   localparam int W    = C_lanes * C_bits;
   localparam int STEP = (C_ddr != 0) ? 2 : 1;

   logic [PW-1:0] p;
   logic [W-1:0]  sr;
   logic [W-1:0]  sr_next;
   logic [W-1:0]  hold;
   logic          fresh;
   logic          load;

   assign load        = (p == PW'(N - 1));
   assign load_strobe = load;

   // Each lane shifts on its own so no bits leak across lane boundaries.
   always_comb begin
      sr_next = '0;
      for (int i = 0; i < C_lanes; i++) begin
         sr_next[i*C_bits +: C_bits] = sr[i*C_bits +: C_bits] >> STEP;
      end
   end

   for (genvar i = 0; i < C_lanes; i++) begin : g_lane
      if (C_ddr != 0) begin : g_ddr
         assign out_d[2*i]   = sr[i*C_bits]     ^ C_invert[i];
         assign out_d[2*i+1] = sr[i*C_bits + 1] ^ C_invert[i];
      end else begin : g_sdr
         assign out_d[2*i]   = sr[i*C_bits] ^ C_invert[i];
         assign out_d[2*i+1] = sr[i*C_bits] ^ C_invert[i];
      end
   end

   always_ff @(posedge clk_shift) begin
      if (reset) begin
         p            <= '0;
         sr           <= '0;
         hold         <= '0;
         fresh        <= 1'b0;
         underrun     <= 1'b0;
         underrun_cnt <= 8'd0;
      end else begin
         p <= load ? '0 : p + PW'(1);
         if (in_valid) begin
            hold <= in_word;
         end
         if (load) begin
            // A strobe in the load cycle bypasses the holding register.
            sr    <= in_valid ? in_word : hold;
            fresh <= 1'b0;
            if (!fresh && !in_valid) begin
               underrun <= 1'b1;
               if (underrun_cnt != 8'hFF) begin
                  underrun_cnt <= underrun_cnt + 8'd1;
               end
            end
         end else begin
            sr <= sr_next;
            if (in_valid) begin
               fresh <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_tmds_lane_serializer.sv
// Directed bench: SDR single-lane and DDR four-lane (lane 3 inverted) instances.
module tb_tmds_lane_serializer;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  a_word;
   logic        a_valid;
   logic        a_strobe;
   logic [1:0]  a_out;
   logic        a_under;
   logic [7:0]  a_cnt;
   logic [39:0] b_word;
   logic        b_valid;
   logic        b_strobe;
   logic [7:0]  b_out;
   logic        b_under;
   logic [7:0]  b_cnt;

   int checks = 0;
   int errors = 0;

   logic       sdr_exp [10];
   logic [1:0] ddr_exp [5];
   logic [1:0] pr;

   always #5 clk = ~clk;

   tmds_lane_serializer #(
      .C_lanes(1), .C_bits(10), .C_ddr(0), .C_invert(1'b0)
   ) u_a (
      .clk_shift(clk), .reset(reset), .in_word(a_word),
      .in_valid(a_valid), .load_strobe(a_strobe), .out_d(a_out),
      .underrun(a_under), .underrun_cnt(a_cnt)
   );

   tmds_lane_serializer #(
      .C_lanes(4), .C_bits(10), .C_ddr(1), .C_invert(4'b1000)
   ) u_b (
      .clk_shift(clk), .reset(reset), .in_word(b_word),
      .in_valid(b_valid), .load_strobe(b_strobe), .out_d(b_out),
      .underrun(b_under), .underrun_cnt(b_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      sdr_exp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      ddr_exp = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b10};
      reset   = 1'b1;
      a_word  = '0;
      a_valid = 1'b0;
      b_word  = '0;
      b_valid = 1'b0;
      tick();
      tick();
      chk("rst_a_out", 32'(a_out), 32'h0);
      chk("rst_b_out", 32'(b_out), 32'hC0);
      chk("rst_a_stb", 32'(a_strobe), 32'h0);
      chk("rst_b_stb", 32'(b_strobe), 32'h0);
      chk("rst_b_und", 32'(b_under), 32'h0);
      chk("rst_b_cnt", 32'(b_cnt), 32'h0);

      reset   = 1'b0;
      a_valid = 1'b1;
      a_word  = 10'h2AB;
      b_valid = 1'b1;
      b_word  = {4{10'h2AB}};
      for (int c = 0; c <= 20; c++) begin
         chk("a_stb", 32'(a_strobe), 32'((c % 10) == 9));
         chk("b_stb", 32'(b_strobe), 32'((c % 5) == 4));
         if (c >= 10) begin
            chk("a_sdr_bit", 32'(a_out), 32'({2{sdr_exp[(c-10) % 10]}}));
         end
         if (c >= 5) begin
            pr = ddr_exp[(c-5) % 5];
            chk("b_ddr_pair", 32'(b_out), 32'({~pr, pr, pr, pr}));
         end
         if (c < 20) begin
            tick();
            a_valid = 1'b0;
            b_valid = 1'b0;
         end
      end
      chk("a_und1", 32'(a_under), 32'h1);
      chk("a_cnt1", 32'(a_cnt), 32'd1);
      chk("b_und3", 32'(b_under), 32'h1);
      chk("b_cnt3", 32'(b_cnt), 32'd3);

      tick();
      tick();
      b_valid = 1'b1;
      b_word  = {4{10'h155}};
      tick();
      b_valid = 1'b0;
      reset   = 1'b1;
      tick();
      chk("mid_a_out", 32'(a_out), 32'h0);
      chk("mid_b_out", 32'(b_out), 32'hC0);
      chk("mid_a_stb", 32'(a_strobe), 32'h0);
      chk("mid_b_stb", 32'(b_strobe), 32'h0);
      chk("mid_a_und", 32'(a_under), 32'h0);
      chk("mid_a_cnt", 32'(a_cnt), 32'h0);
      chk("mid_b_und", 32'(b_under), 32'h0);
      chk("mid_b_cnt", 32'(b_cnt), 32'h0);

      reset = 1'b0;
      for (int r = 0; r <= 35; r++) begin
         chk("r_a_stb", 32'(a_strobe), 32'((r % 10) == 9));
         chk("r_b_stb", 32'(b_strobe), 32'((r % 5) == 4));
         if (r >= 5 && r <= 9) begin
            chk("inv_zero", 32'(b_out), 32'hC0);
         end
         if (r >= 10 && r <= 14) begin
            chk("bypass_3ff", 32'(b_out), 32'h3F);
         end
         if (r >= 15) begin
            chk("word_155", 32'(b_out), 32'h95);
         end
         if (r == 5) begin
            chk("flag_clr_und", 32'(b_under), 32'h1);
            chk("flag_clr_cnt", 32'(b_cnt), 32'd1);
            chk("a_no_und", 32'(a_under), 32'h0);
         end
         if (r == 10 || r == 15) begin
            chk("bypass_und", 32'(b_under), 32'h1);
            chk("bypass_cnt", 32'(b_cnt), 32'd1);
         end
         if (r == 30) begin
            chk("repeat_cnt", 32'(b_cnt), 32'd4);
         end
         b_valid = (r == 9) || (r == 10);
         b_word  = (r == 9) ? {4{10'h3FF}} : {4{10'h155}};
         if (r < 35) begin
            tick();
         end
      end
      b_valid = 1'b0;

      for (int k = 0; k < 1500; k++) begin
         tick();
      end
      chk("sat_cnt", 32'(b_cnt), 32'd255);
      chk("sat_und", 32'(b_under), 32'h1);
      chk("a_cnt_long", 32'(a_cnt), 32'd153);
      chk("sat_word", 32'(b_out), 32'h95);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
